// File: rtl/add_selector_pkg.sv
// Shared constants, note index type and triangle shaper for the tone sequencer.
package add_selector_pkg;

   localparam int unsigned ACC_W = 32;
   localparam int unsigned PWM_W = 8;
   localparam int unsigned IDX_W = 3;

   typedef enum logic [IDX_W-1:0] {
      NOTE_C4 = 3'd0,
      NOTE_D4 = 3'd1,
      NOTE_E4 = 3'd2,
      NOTE_F4 = 3'd3,
      NOTE_G4 = 3'd4,
      NOTE_A4 = 3'd5,
      NOTE_B4 = 3'd6,
      NOTE_C5 = 3'd7
   } note_e;

   // round(f * 2^32 / 100 MHz) for C4..C5
   localparam logic [ACC_W-1:0] NOTE_TABLE [8] = '{
      32'd11237, 32'd12613, 32'd14157, 32'd14999,
      32'd16836, 32'd18898, 32'd21212, 32'd22473
   };

   // Fold the top phase byte into a 0..254 triangle.
   function automatic logic [PWM_W-1:0] tri_shape(input logic [7:0] p);
      tri_shape = p[7] ? {~p[6:0], 1'b0} : {p[6:0], 1'b0};
   endfunction

endpackage

// File: rtl/add_selector_pwm_dac.sv
// Free-running 8-bit PWM counter and comparator producing the 1-bit audio pin.
module pwm_dac
   import add_selector_pkg::*;
(
   input  logic             CLK_IN,
   input  logic             RST,
   input  logic [PWM_W-1:0] lvl,
   output logic             snd_pwm
);

   logic [PWM_W-1:0] pc_q, pc_d;
   logic             snd_d;

   always_comb begin
      pc_d  = pc_q + PWM_W'(1);
      snd_d = (lvl > pc_q);
   end

   always_ff @(posedge CLK_IN or posedge RST) begin
      if (RST) begin
         pc_q    <= '0;
         snd_pwm <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         snd_pwm <= snd_d;
      end
   end

endmodule

// File: rtl/add_selector.sv
// Eight-note scale sequencer: note timer, addend selector, phase accumulator,
// triangle shaper, feeding the PWM DAC.
module add_selector #(
   parameter int unsigned CLK_HZ   = 100_000_000,
   parameter int unsigned NOTE_MS  = 250,
   parameter int unsigned NOTE_CYC = CLK_HZ / 1000 * NOTE_MS
) (
   input  logic CLK_IN,
   input  logic RST,
   output logic snd_pwm
);
   import add_selector_pkg::*;

   localparam int unsigned TMR_W = (NOTE_CYC > 1) ? $clog2(NOTE_CYC) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(NOTE_CYC - 1);

   logic [TMR_W-1:0] tmr_q, tmr_d;
   note_e            idx_q, idx_d;
   logic [ACC_W-1:0] add_q, add_d;
   logic [ACC_W-1:0] ph_q,  ph_d;
   logic [PWM_W-1:0] lvl_q, lvl_d;

   always_comb begin
      tmr_d = tmr_q + TMR_W'(1);
      idx_d = idx_q;
      if (tmr_q == TMR_LAST) begin
         tmr_d = '0;
         idx_d = note_e'(idx_q + IDX_W'(1));
      end
      // Each stage reads the previous stage's register: idx -> add -> ph -> lvl.
      add_d = NOTE_TABLE[idx_q];
      ph_d  = ph_q + add_q;
      lvl_d = tri_shape(ph_q[ACC_W-1 -: 8]);
   end

   always_ff @(posedge CLK_IN or posedge RST) begin
      if (RST) begin
         tmr_q <= '0;
         idx_q <= NOTE_C4;
         add_q <= '0;
         ph_q  <= '0;
         lvl_q <= '0;
      end else begin
         tmr_q <= tmr_d;
         idx_q <= idx_d;
         add_q <= add_d;
         ph_q  <= ph_d;
         lvl_q <= lvl_d;
      end
   end

   pwm_dac u_pwm (
      .CLK_IN  (CLK_IN),
      .RST     (RST),
      .lvl     (lvl_q),
      .snd_pwm (snd_pwm)
   );

endmodule

// File: tb/tb_add_selector.sv
// Directed bench for add_selector (shortened note length) and a pwm_dac unit instance.
module tb_add_selector;

   localparam int unsigned NC = 4096;

   logic CLK_IN = 1'b0;
   logic RST    = 1'b1;
   logic snd_pwm;

   logic       u_rst = 1'b1;
   logic [7:0] u_lvl = 8'd0;
   logic       u_snd;

   always #5 CLK_IN = ~CLK_IN;

   add_selector #(.NOTE_CYC(NC)) dut (
      .CLK_IN  (CLK_IN),
      .RST     (RST),
      .snd_pwm (snd_pwm)
   );

   pwm_dac u_dac (
      .CLK_IN  (CLK_IN),
      .RST     (u_rst),
      .lvl     (u_lvl),
      .snd_pwm (u_snd)
   );

   typedef struct {
      int unsigned edge_n;
      logic [2:0]  idx;
      logic [31:0] add;
   } note_vec_t;

   typedef struct {
      logic [7:0]  lvl;
      int unsigned high;
   } pwm_vec_t;

   logic [31:0] ADDS [8] = '{32'd11237, 32'd12613, 32'd14157, 32'd14999,
                             32'd16836, 32'd18898, 32'd21212, 32'd22473};

   int unsigned n_pass = 0;
   int unsigned n_total = 0;

   int unsigned m_tmr, n_edge;
   logic [2:0]  m_idx;
   logic [31:0] m_add, m_ph;
   logic [7:0]  m_lvl, m_pc;
   logic        m_snd;
   int unsigned err_idx = 0, err_add = 0, err_ph = 0, err_lvl = 0, err_snd = 0;
   int unsigned hi_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   function automatic logic [7:0] tri_ref(input logic [7:0] p);
      int unsigned v;
      v = (p < 8'd128) ? 2 * int'(p) : 2 * (255 - int'(p));
      return v[7:0];
   endfunction

   task automatic model_reset();
      m_tmr = 0; m_idx = '0; m_add = '0; m_ph = '0;
      m_lvl = '0; m_pc = '0; m_snd = 1'b0; n_edge = 0;
   endtask

   task automatic step();
      logic        nsnd;
      logic [7:0]  nlvl, npc;
      logic [31:0] nph, nadd;
      logic [2:0]  di;
      nsnd = (m_lvl > m_pc);
      npc  = m_pc + 8'd1;
      nlvl = tri_ref(m_ph[31:24]);
      nph  = m_ph + m_add;
      nadd = ADDS[m_idx];
      @(posedge CLK_IN);
      if (m_tmr == NC - 1) begin
         m_tmr = 0;
         m_idx = m_idx + 3'd1;
      end else begin
         m_tmr = m_tmr + 1;
      end
      m_snd = nsnd; m_pc = npc; m_lvl = nlvl; m_ph = nph; m_add = nadd;
      n_edge++;
      #1;
      di = dut.idx_q;
      if (di !== m_idx) err_idx++;
      if (dut.add_q !== m_add) err_add++;
      if (dut.ph_q !== m_ph) err_ph++;
      if (dut.lvl_q !== m_lvl) err_lvl++;
      if (snd_pwm !== m_snd) err_snd++;
      if (snd_pwm === 1'b1) hi_cnt++;
   endtask

   note_vec_t nv [17];
   pwm_vec_t  pv [6];

   initial begin
      int unsigned vi;
      int unsigned rerr;
      int unsigned guard;
      logic [2:0]  di;

      nv = '{
         '{1,      3'd0, 32'd11237},
         '{NC,     3'd1, 32'd11237}, '{NC+1,   3'd1, 32'd12613},
         '{2*NC,   3'd2, 32'd12613}, '{2*NC+1, 3'd2, 32'd14157},
         '{3*NC,   3'd3, 32'd14157}, '{3*NC+1, 3'd3, 32'd14999},
         '{4*NC,   3'd4, 32'd14999}, '{4*NC+1, 3'd4, 32'd16836},
         '{5*NC,   3'd5, 32'd16836}, '{5*NC+1, 3'd5, 32'd18898},
         '{6*NC,   3'd6, 32'd18898}, '{6*NC+1, 3'd6, 32'd21212},
         '{7*NC,   3'd7, 32'd21212}, '{7*NC+1, 3'd7, 32'd22473},
         '{8*NC,   3'd0, 32'd22473}, '{8*NC+1, 3'd0, 32'd11237}
      };
      pv = '{ '{8'd0, 0}, '{8'd1, 1}, '{8'd128, 128},
              '{8'd200, 200}, '{8'd254, 254}, '{8'd255, 255} };

      // Reset held for 35 us
      rerr = 0;
      repeat (3500) begin
         @(negedge CLK_IN);
         di = dut.idx_q;
         if (snd_pwm !== 1'b0 || dut.ph_q !== 32'd0 || di !== 3'd0) rerr++;
      end
      check("reset_hold_errs", rerr, 0);

      @(negedge CLK_IN);
      RST = 1'b0;
      model_reset();

      vi = 0;
      while (n_edge < 8 * NC + 16) begin
         step();
         if (n_edge == 1) check("first_ph", dut.ph_q, 32'd0);
         if (n_edge == 2) check("second_ph", dut.ph_q, 32'd11237);
         if (n_edge == 3) check("third_ph", dut.ph_q, 32'd22474);
         if (vi < 17 && n_edge == nv[vi].edge_n) begin
            di = dut.idx_q;
            check($sformatf("idx_e%0d", n_edge), {29'd0, di}, {29'd0, nv[vi].idx});
            check($sformatf("add_e%0d", n_edge), dut.add_q, nv[vi].add);
            vi++;
         end
      end
      check("note_vectors_seen", vi, 17);
      check("snd_toggles", (hi_cnt > 0) ? 32'd1 : 32'd0, 32'd1);

      // Mid-run reset while in F4 with the output high
      guard = 0;
      while (!(m_idx == 3'd3 && m_snd) && guard < 5 * NC) begin
         step();
         guard++;
      end
      check("reach_f4_high", (m_idx == 3'd3 && m_snd) ? 32'd1 : 32'd0, 32'd1);
      @(negedge CLK_IN);
      #2 RST = 1'b1;
      #1;
      di = dut.idx_q;
      check("async_snd", {31'd0, snd_pwm}, 32'd0);
      check("async_tmr", 32'(dut.tmr_q), 32'd0);
      check("async_idx", {29'd0, di}, 32'd0);
      check("async_add", dut.add_q, 32'd0);
      check("async_ph", dut.ph_q, 32'd0);
      check("async_lvl", {24'd0, dut.lvl_q}, 32'd0);
      check("async_pc", {24'd0, dut.u_pwm.pc_q}, 32'd0);
      rerr = 0;
      repeat (3) begin
         @(posedge CLK_IN);
         #1;
         if (snd_pwm !== 1'b0 || dut.ph_q !== 32'd0 || dut.add_q !== 32'd0) rerr++;
      end
      check("midreset_hold_errs", rerr, 0);
      @(negedge CLK_IN);
      RST = 1'b0;
      model_reset();
      step();
      di = dut.idx_q;
      check("restart_add", dut.add_q, 32'd11237);
      check("restart_ph", dut.ph_q, 32'd0);
      check("restart_idx", {29'd0, di}, 32'd0);
      step();
      check("restart_ph2", dut.ph_q, 32'd11237);
      repeat (600) step();

      check("track_idx_errs", err_idx, 0);
      check("track_add_errs", err_add, 0);
      check("track_ph_errs", err_ph, 0);
      check("track_lvl_errs", err_lvl, 0);
      check("track_snd_errs", err_snd, 0);

      // PWM DAC duty: high cycles per 256-cycle period equal lvl
      @(negedge CLK_IN);
      u_rst = 1'b0;
      foreach (pv[i]) begin
         int unsigned cnt;
         @(negedge CLK_IN);
         u_lvl = pv[i].lvl;
         cnt = 0;
         repeat (256) begin
            @(posedge CLK_IN);
            #1;
            if (u_snd === 1'b1) cnt++;
         end
         check($sformatf("duty_lvl%0d", pv[i].lvl), cnt, pv[i].high);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
